// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter.
//   tx_state_t : frame sequencer states
//   PAR_*      : parity mode constants for the PARITY parameter
//   parity_bit : parity of the low nbits of a payload for a given mode
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic logic parity_bit(input logic [7:0] data,
                                      input int unsigned nbits,
                                      input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, pulsing tick_o
// during the last cycle of each bit period.
//   clk   : clock, rising edge
//   clr_i : synchronous clear, holds the count at 0
//   tick_o: high in the final cycle of a bit period
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned    CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (clr_i || tick_o) cnt_q <= '0;
    else                 cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start bit, DATA_BITS payload bits LSB first,
// optional parity bit, STOP_BITS stop bits.
//   clk      : clock, rising edge
//   srst_n   : synchronous active-low reset
//   in_valid : payload offered
//   in_ready : payload accepted this cycle if in_valid is high
//   in_data  : payload
//   tx       : registered serial line, idle high
//   busy     : high while a frame bit is on the line
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 srst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned    BCW      = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BCW-1:0]       bit_q;
  logic                 stop_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 rdy_en_q;
  logic                 tick;
  logic                 last_stop;
  logic                 accept;
  logic                 baud_clr;

  // Counter idles at zero so a frame started from IDLE gets a full start
  // bit; back-to-back frames rely on the natural wrap at the last stop tick.
  assign baud_clr = !srst_n || (state_q == ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .clr_i (baud_clr),
    .tick_o(tick)
  );

  assign last_stop = (STOP_BITS == 1) || stop_q;

  // rdy_en_q keeps in_ready low on reset edges and for the cycle after.
  assign in_ready = rdy_en_q &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_STOP) && last_stop && tick));
  assign accept   = in_valid && in_ready;

  assign tx   = tx_q;
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept) begin
        state_q <= ST_START;
        shift_q <= in_data;
        par_q   <= parity_bit(8'(in_data), DATA_BITS, PARITY);
        bit_q   <= '0;
        stop_q  <= 1'b0;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else if (tick) begin
        unique case (state_q)
          ST_START: begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end
          ST_DATA: begin
            if (bit_q == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
              end
            end else begin
              bit_q   <= bit_q + BCW'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
          ST_PARITY: begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
          end
          ST_STOP: begin
            if (last_stop) begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              stop_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: four instances (8N1, 8E1, 8O1, 7N2)
// at 4 clocks per bit, checked cycle by cycle against a frame model.
module tb_uart_tx_framed;

  localparam int CPB = 4;
  localparam int NI  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst_n;
  logic [NI-1:0] iv;
  logic [7:0]    id [NI];
  logic [NI-1:0] tx_w;
  logic [NI-1:0] busy_w;
  logic [NI-1:0] rdy_w;

  int cfg_db  [NI] = '{8, 8, 8, 7};
  int cfg_par [NI] = '{0, 2, 1, 0};
  int cfg_sb  [NI] = '{1, 1, 1, 2};

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .srst_n(srst_n), .in_valid(iv[0]), .in_ready(rdy_w[0]),
    .in_data(id[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .srst_n(srst_n), .in_valid(iv[1]), .in_ready(rdy_w[1]),
    .in_data(id[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .srst_n(srst_n), .in_valid(iv[2]), .in_ready(rdy_w[2]),
    .in_data(id[2]), .tx(tx_w[2]), .busy(busy_w[2]));
  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .srst_n(srst_n), .in_valid(iv[3]), .in_ready(rdy_w[3]),
    .in_data(id[3][6:0]), .tx(tx_w[3]), .busy(busy_w[3]));

  typedef struct {
    int         k;
    logic [7:0] d;
    int         len;
    logic [15:0] bits;   // bit i = level of the i-th transmitted bit
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int frame_len(input int k);
    return CPB * (1 + cfg_db[k] + ((cfg_par[k] != 0) ? 1 : 0) + cfg_sb[k]);
  endfunction

  // Expected line level c cycles after the accept edge.
  function automatic int exp_tx(input int k, input logic [7:0] d, input int c);
    int b;
    int p;
    b = c / CPB;
    p = 0;
    for (int i = 0; i < cfg_db[k]; i++) p = p ^ int'(d[i]);
    if (b == 0) return 0;
    if (b <= cfg_db[k]) return int'(d[b-1]);
    if (cfg_par[k] != 0 && b == cfg_db[k] + 1) return (cfg_par[k] == 2) ? p : 1 - p;
    return 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int k, input logic [7:0] d);
    int n;
    n = 0;
    while (!rdy_w[k] && n < 200) begin
      step();
      n++;
    end
    check($sformatf("i%0d ready_timeout", k), (n < 200) ? 1 : 0, 1);
    iv[k] = 1'b1;
    id[k] = d;
    step();
  endtask

  task automatic check_frame(input int k, input logic [7:0] d, input bit scramble,
                             input bit chain, input logic [7:0] nxt,
                             output int busy_cnt, output logic [15:0] bits);
    int L;
    L = frame_len(k);
    busy_cnt = 0;
    bits = '0;
    for (int c = 0; c < L; c++) begin
      check($sformatf("i%0d tx c%0d", k, c), int'(tx_w[k]), exp_tx(k, d, c));
      check($sformatf("i%0d busy c%0d", k, c), int'(busy_w[k]), 1);
      check($sformatf("i%0d in_ready c%0d", k, c), int'(rdy_w[k]), (c == L - 1) ? 1 : 0);
      if (busy_w[k]) busy_cnt++;
      if (c % CPB == CPB / 2) bits[c / CPB] = tx_w[k];
      if (c == L - 1) begin
        if (chain) begin
          iv[k] = 1'b1;
          id[k] = nxt;
        end else begin
          iv[k] = 1'b0;
        end
      end else if (scramble) begin
        iv[k] = 1'b1;
        id[k] = 8'($urandom);
      end else begin
        iv[k] = 1'b0;
      end
      step();
    end
  endtask

  task automatic check_idle(input int k, input string nm);
    check($sformatf("i%0d %s tx", k, nm), int'(tx_w[k]), 1);
    check($sformatf("i%0d %s busy", k, nm), int'(busy_w[k]), 0);
    check($sformatf("i%0d %s in_ready", k, nm), int'(rdy_w[k]), 1);
  endtask

  initial begin
    vec_t        tbl [6];
    int          bc;
    logic [15:0] bits;
    int          k;
    logic [7:0]  d;
    logic [7:0]  d2;
    bit          scr;
    bit          chn;

    tbl[0] = '{0, 8'hA5, 40, 16'h034A};
    tbl[1] = '{1, 8'h07, 44, 16'h060E};
    tbl[2] = '{2, 8'h07, 44, 16'h040E};
    tbl[3] = '{3, 8'h7F, 40, 16'h03FE};
    tbl[4] = '{0, 8'h00, 40, 16'h0200};
    tbl[5] = '{1, 8'h00, 44, 16'h0400};

    iv = '0;
    for (int i = 0; i < NI; i++) id[i] = 8'h00;
    srst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d reset tx", i), int'(tx_w[i]), 1);
      check($sformatf("i%0d reset busy", i), int'(busy_w[i]), 0);
      check($sformatf("i%0d reset in_ready", i), int'(rdy_w[i]), 0);
    end
    srst_n = 1'b1;
    step();
    for (int i = 0; i < NI; i++) check_idle(i, "post_reset");

    // Directed frames with hand-derived bit patterns and lengths
    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].k, tbl[i].d);
      check_frame(tbl[i].k, tbl[i].d, 1'b0, 1'b0, 8'h00, bc, bits);
      check($sformatf("vec%0d busy_len", i), bc, tbl[i].len);
      check($sformatf("vec%0d bits", i), int'(bits), int'(tbl[i].bits));
      check_idle(tbl[i].k, "after_vec");
    end

    // Back-to-back: valid held high, second start immediately after last stop
    accept(0, 8'h55);
    check_frame(0, 8'h55, 1'b0, 1'b1, 8'hAA, bc, bits);
    check_frame(0, 8'hAA, 1'b0, 1'b0, 8'h00, bc, bits);
    check_idle(0, "after_b2b");

    // Reset during data bit 3 of 0xFF
    accept(0, 8'hFF);
    iv[0] = 1'b0;
    repeat (17) step();
    check("rst_mid tx_before", int'(tx_w[0]), 1);
    check("rst_mid busy_before", int'(busy_w[0]), 1);
    srst_n = 1'b0;
    step();
    check("rst_mid tx", int'(tx_w[0]), 1);
    check("rst_mid busy", int'(busy_w[0]), 0);
    check("rst_mid in_ready", int'(rdy_w[0]), 0);
    srst_n = 1'b1;
    step();
    check_idle(0, "rst_release");
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("rst_noresume tx c%0d", c), int'(tx_w[0]), 1);
      check($sformatf("rst_noresume busy c%0d", c), int'(busy_w[0]), 0);
    end
    accept(0, 8'h00);
    check_frame(0, 8'h00, 1'b0, 1'b0, 8'h00, bc, bits);
    check_idle(0, "after_rst_frame");

    // in_data churning mid-frame with valid high
    accept(1, 8'h3C);
    check_frame(1, 8'h3C, 1'b1, 1'b0, 8'h00, bc, bits);
    check_idle(1, "after_scramble");

    // Randomized frames, sometimes chained, sometimes with churning input
    for (int r = 0; r < 30; r++) begin
      k   = int'($urandom_range(0, NI - 1));
      d   = 8'($urandom);
      d2  = 8'($urandom);
      scr = 1'($urandom);
      chn = 1'($urandom);
      accept(k, d);
      check_frame(k, d, scr, chn, d2, bc, bits);
      check($sformatf("rnd%0d busy_len", r), bc, frame_len(k));
      if (chn) check_frame(k, d2, scr, 1'b0, 8'h00, bc, bits);
      check_idle(k, "after_rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
